// File: rtl/pmem_line_responder.sv
// ----------------------------------------------------------------------------
// pmem_line_responder
//
// Main-memory model for the L2 pmem port. One 256-bit line read or write is
// accepted at a time. The request is held for a programmable latency and then
// completed against an internal line array. Completion is signalled by a
// single-cycle pmem_resp pulse.
//
// Parameters:
//   LINE_IDX_BITS  line-index width; the array holds 2**LINE_IDX_BITS lines
//   READ_LATENCY   acceptance-to-resp cycles for reads  (legal 1..255)
//   WRITE_LATENCY  acceptance-to-resp cycles for writes (legal 1..255)
//
// Ports:
//   clk           clock; all state changes on the rising edge
//   rst           synchronous active-high reset
//   pmem_read     read request level, held until pmem_resp
//   pmem_write    write request level, held until pmem_resp (wins over read)
//   pmem_address  byte address; [LINE_IDX_BITS+4:5] is the line index
//   pmem_wdata    write line data
//   pmem_rdata    registered read line data, held until the next read completes
//   pmem_resp     one-cycle completion pulse per accepted request
// ----------------------------------------------------------------------------
module pmem_line_responder #(
    parameter int unsigned LINE_IDX_BITS = 10,
    parameter int unsigned READ_LATENCY  = 12,
    parameter int unsigned WRITE_LATENCY = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [31:0]  pmem_address,
    input  logic [255:0] pmem_wdata,
    output logic [255:0] pmem_rdata,
    output logic         pmem_resp
);

    localparam int unsigned Depth = 1 << LINE_IDX_BITS;

    // Counter preload values; a preload of 0 means the request completes on
    // the acceptance edge itself.
    localparam logic [7:0] RdLoad = 8'(READ_LATENCY - 1);
    localparam logic [7:0] WrLoad = 8'(WRITE_LATENCY - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]               state_q, state_d;
    logic                     op_write_q, op_write_d;
    logic [LINE_IDX_BITS-1:0] idx_q, idx_d;
    logic [255:0]             wdata_q, wdata_d;
    logic [7:0]               cnt_q, cnt_d;
    logic [255:0]             rdata_q;

    logic [LINE_IDX_BITS-1:0] req_idx;
    logic                     req_valid;
    logic                     op_req_live;

    // Completion strobe: asserted in the cycle whose closing edge enters RESP.
    logic                     commit;
    logic                     commit_write;
    logic [LINE_IDX_BITS-1:0] commit_idx;
    logic [255:0]             commit_wdata;

    logic [255:0]             mem [Depth];

    // Address bits outside the line index are don't-care; upper bits alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{pmem_address[31:LINE_IDX_BITS+5], pmem_address[4:0]};

    assign req_idx     = pmem_address[LINE_IDX_BITS+4:5];
    assign req_valid   = pmem_read | pmem_write;
    // Only the request line of the latched op keeps the transaction alive.
    assign op_req_live = op_write_q ? pmem_write : pmem_read;

    always_comb begin
        state_d      = state_q;
        op_write_d   = op_write_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        commit       = 1'b0;
        commit_write = op_write_q;
        commit_idx   = idx_q;
        commit_wdata = wdata_q;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_write_d = pmem_write;
                    idx_d      = req_idx;
                    wdata_d    = pmem_wdata;
                    cnt_d      = pmem_write ? WrLoad : RdLoad;
                    if (cnt_d == 8'd0) begin
                        // Latency of one: complete straight from the live inputs.
                        state_d      = StResp;
                        commit       = 1'b1;
                        commit_write = pmem_write;
                        commit_idx   = req_idx;
                        commit_wdata = pmem_wdata;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (!op_req_live) begin
                    // Initiator withdrew the request: drop it silently.
                    state_d = StIdle;
                end else begin
                    cnt_d = (cnt_q != 8'd0) ? cnt_q - 8'd1 : 8'd0;
                    if (cnt_d == 8'd0) begin
                        state_d = StResp;
                        commit  = 1'b1;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            op_write_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            cnt_q      <= 8'd0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            op_write_q <= op_write_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            if (commit && !commit_write) begin
                rdata_q <= mem[commit_idx];
            end
        end
    end

    // Line array has no reset; a commit coinciding with rst is discarded.
    always_ff @(posedge clk) begin
        if (!rst && commit && commit_write) begin
            mem[commit_idx] <= commit_wdata;
        end
    end

    assign pmem_rdata = rdata_q;
    assign pmem_resp  = (state_q == StResp);

endmodule

// File: tb/tb_pmem_line_responder.sv
module tb_pmem_line_responder;

    localparam int unsigned IdxBits = 10;
    localparam int unsigned Lines   = 1 << IdxBits;
    localparam int unsigned SlowLat = 12;
    localparam int unsigned FastLat = 1;

    typedef struct {
        longint unsigned due;
        bit              chk;
        logic [255:0]    data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd    [2];
    logic         wr    [2];
    logic [31:0]  addr  [2];
    logic [255:0] wdata [2];
    logic [255:0] rdata [2];
    logic         resp  [2];

    longint unsigned cyc = 0;
    int              n_checks = 0;
    int              n_fail = 0;
    bit              mon_en = 1'b0;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model: plain line arrays plus the last value a read returned.
    logic [255:0] model_mem [2][Lines];
    bit           model_vld [2][Lines];
    logic [255:0] last_rd   [2];
    bit           last_ok   [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pmem_line_responder #(
        .LINE_IDX_BITS (IdxBits),
        .READ_LATENCY  (SlowLat),
        .WRITE_LATENCY (SlowLat)
    ) u_slow (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (rd[0]),
        .pmem_write   (wr[0]),
        .pmem_address (addr[0]),
        .pmem_wdata   (wdata[0]),
        .pmem_rdata   (rdata[0]),
        .pmem_resp    (resp[0])
    );

    pmem_line_responder #(
        .LINE_IDX_BITS (IdxBits),
        .READ_LATENCY  (FastLat),
        .WRITE_LATENCY (FastLat)
    ) u_fast (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (rd[1]),
        .pmem_write   (wr[1]),
        .pmem_address (addr[1]),
        .pmem_wdata   (wdata[1]),
        .pmem_rdata   (rdata[1]),
        .pmem_resp    (resp[1])
    );

    function automatic void check(string name, logic [255:0] act, logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int unsigned lat_of(int k);
        return (k == 0) ? SlowLat : FastLat;
    endfunction

    // Monitor: one instance per call, sampled on the falling edge.
    task automatic mon_one(int k);
        exp_t e;
        bit   have;
        have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (!have) begin
            check($sformatf("spurious_resp%0d", k), 256'(resp[k]), 256'(0));
        end else begin
            e = (k == 0) ? q0[0] : q1[0];
            if (resp[k] === 1'b1) begin
                if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                check($sformatf("resp_cycle%0d", k), 256'(cyc), 256'(e.due));
                if (e.chk) check($sformatf("rdata%0d", k), rdata[k], e.data);
            end else if (cyc >= e.due) begin
                if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                check($sformatf("missing_resp%0d", k), 256'(resp[k]), 256'(1));
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_one(0);
            mon_one(1);
        end
    end

    // Called #1 after a rising edge with the target DUT idle. Holds the request
    // until the edge after resp, then drops it.
    task automatic issue(int k, bit do_wr, bit do_rd, logic [31:0] a, logic [255:0] d,
                         bit scramble);
        exp_t        e;
        int unsigned idx;
        int unsigned lat;
        idx      = int'(a[IdxBits+4:5]);
        lat      = lat_of(k);
        wr[k]    = do_wr;
        rd[k]    = do_rd;
        addr[k]  = a;
        wdata[k] = d;
        e.due    = cyc + lat;
        if (do_wr) begin
            model_mem[k][idx] = d;
            model_vld[k][idx] = 1'b1;
            e.chk  = last_ok[k];   // writes leave rdata untouched
            e.data = last_rd[k];
        end else begin
            e.chk      = model_vld[k][idx];
            e.data     = model_mem[k][idx];
            last_rd[k] = e.data;
            last_ok[k] = e.chk;
        end
        if (k == 0) q0.push_back(e); else q1.push_back(e);
        repeat (lat) begin
            @(posedge clk);
            #1;
            if (scramble) begin
                addr[k]  = $urandom;
                wdata[k] = rand256();
            end
        end
        @(posedge clk);
        #1;
        wr[k] = 1'b0;
        rd[k] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [255:0] pat_a, pat_b, pat_c, pat_d, pat_e, pat_p1, pat_p2;
        logic [31:0]  a;
        int unsigned  op;

        pat_a  = {8{32'hDEADBEEF}};
        pat_a[31:0] = 32'h0123_4567;
        pat_b  = rand256();
        pat_c  = rand256();
        pat_d  = rand256();
        pat_e  = rand256();
        pat_p1 = rand256();
        pat_p2 = rand256();

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < Lines; i++) model_vld[k][i] = 1'b0;
            last_rd[k] = '0;
            last_ok[k] = 1'b1;
        end

        // Reset with random request activity.
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rd[k]    = 1'($urandom_range(0, 1));
            wr[k]    = 1'($urandom_range(0, 1));
            addr[k]  = $urandom;
            wdata[k] = rand256();
        end
        @(posedge clk);
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rd[k] = 1'b0;
            wr[k] = 1'b0;
        end
        check("reset_rdata0", rdata[0], '0);
        check("reset_rdata1", rdata[1], '0);
        check("reset_resp0", 256'(resp[0]), 256'(0));
        check("reset_resp1", 256'(resp[1]), 256'(0));
        repeat (20) @(posedge clk);
        #1;

        // Write then read, latency 12.
        issue(0, 1'b1, 1'b0, 32'h0000_0040, pat_a, 1'b0);
        issue(0, 1'b0, 1'b1, 32'h0000_0040, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        // Latency 1: alias wrap and write priority.
        issue(1, 1'b1, 1'b0, 32'h0000_0020, pat_b, 1'b0);
        issue(1, 1'b0, 1'b1, 32'h0000_8020, '0, 1'b0);
        issue(1, 1'b1, 1'b1, 32'h0000_0060, pat_c, 1'b0);
        issue(1, 1'b0, 1'b1, 32'h0000_0060, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        // Abort: write withdrawn in WAIT must not land.
        issue(0, 1'b1, 1'b0, 32'h0000_0080, pat_p1, 1'b0);
        wr[0]    = 1'b1;
        addr[0]  = 32'h0000_0080;
        wdata[0] = pat_d;
        repeat (5) @(posedge clk);
        #1;
        wr[0] = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        issue(0, 1'b0, 1'b1, 32'h0000_0080, '0, 1'b0);

        // Reset lands on the edge that would commit the write.
        issue(0, 1'b1, 1'b0, 32'h0000_00A0, pat_p2, 1'b0);
        wr[0]    = 1'b1;
        addr[0]  = 32'h0000_00A0;
        wdata[0] = pat_e;
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        wr[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            last_rd[k] = '0;
            last_ok[k] = 1'b1;
        end
        check("midrst_rdata0", rdata[0], '0);
        check("midrst_resp0", 256'(resp[0]), 256'(0));
        issue(0, 1'b0, 1'b1, 32'h0000_00A0, '0, 1'b0);

        // Randomized back-to-back traffic over 64 lines on both instances.
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 200; n++) begin
                op = $urandom_range(0, 2);
                a  = ($urandom & 32'hFFFF_8000) | (32'($urandom_range(0, 63)) << 5)
                   | 32'($urandom_range(0, 31));
                issue(k, op != 1, op != 0, a, rand256(), 1'b1);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end

        repeat (20) @(posedge clk);
        #1;
        check("drain0", 256'(q0.size()), 256'(0));
        check("drain1", 256'(q1.size()), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pmem_line_responder.md
# pmem_line_responder

Physical-memory responder for the L2 cache's `pmem_*` port. It accepts one 256-bit line read or write at a time from the L2 miss/writeback logic and holds the request for a programmable number of cycles. It then completes the request against an internal line array and acknowledges with a single-cycle `pmem_resp`. It sits below the L2 in the hierarchy and serves as the synthesizable main-memory model for system simulation.

## Interface
- `LINE_IDX_BITS`, 10, number of line-index address bits; array depth is 2^LINE_IDX_BITS lines of 256 bits.
- `READ_LATENCY`, 12, cycles from request acceptance to `pmem_resp` for reads; legal range is 1..255.
- `WRITE_LATENCY`, 12, cycles from request acceptance to `pmem_resp` for writes; legal range is 1..255.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `pmem_read`  in  1  line read request; level, held by the initiator until `pmem_resp`.
- `pmem_write`  in  1  line write request; level, held by the initiator until `pmem_resp`.
- `pmem_address`  in  32  byte address; bits [4:0] are ignored, and bits [LINE_IDX_BITS+4:5] form the line index.
- `pmem_wdata`  in  256  write line data.
- `pmem_rdata`  out  256  read line data; registered.
- `pmem_resp`  out  1  completion pulse, exactly one cycle per accepted request.

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- **IDLE:** if `pmem_write` is high, or `pmem_read` is high:
  - latch the operation (write has priority when both are high), the line index and `pmem_wdata`;
  - load the 8-bit counter with LAT-1;
  - if LAT==1, go to RESP; otherwise go to WAIT.
- **WAIT:** decrement the counter each cycle.
  - When the counter reaches 0, go to RESP.
  - Abort: if the latched operation's request line is sampled low in WAIT, return to IDLE. No array write occurs and no `pmem_resp` is issued.
- **Entering RESP:**
  - write op: array[idx] <= latched wdata.
  - read op: `pmem_rdata` <= array[idx].
  - Both happen on the same edge.
- **RESP:** `pmem_resp`=1 for this one cycle, then go unconditionally to IDLE.
  - Requests that are still high in the RESP cycle are not re-accepted, because acceptance only occurs in IDLE.
- `pmem_rdata` holds its value until the next read completes. Writes do not change it.
- Line index wrap: address bits above LINE_IDX_BITS+4 are ignored, so addresses alias modulo the array size.
- Read-after-write to the same line returns the new data. Back-to-back operation is legal: write RESP, then IDLE, then accept the read.
- Address and wdata changes during WAIT are ignored, because the values latched at acceptance are used.

## Timing
- Reset values:
  - state=IDLE, counter=0;
  - `pmem_resp`=0, `pmem_rdata`=0.
  - Array contents are not modified by reset.
- Reset mid-operation (in WAIT or RESP): go to IDLE on that edge, issue no `pmem_resp`, and perform no array write for a pending write.
  - A write whose RESP entry edge coincides with `rst` high is not committed.
- Latency: a request first seen high in IDLE at cycle T produces `pmem_resp` high in cycle T+LAT. LAT is `READ_LATENCY` or `WRITE_LATENCY` according to the latched op.
- `pmem_rdata` is valid in the RESP cycle and afterwards.
- Minimum spacing between accepted requests is LAT+1 cycles (RESP, then IDLE).
- The counter is 8 bits wide with no wrap: the LAT range is limited to 255 and decrement stops at 0.
- The design is single-outstanding; there is no queueing.

## Test plan
- **Reset:** assert `rst` 2 cycles with random inputs → `pmem_resp`=0, `pmem_rdata`=0, FSM in IDLE; no response for 20 cycles while requests stay low.
- **Write then read:**
  - write 0xDEADBEEF…(256-bit pattern A) to address 0x0000_0040 with WRITE_LATENCY=12 → `pmem_resp` pulses once at T+12.
  - read the same address → `pmem_resp` at T'+12 with `pmem_rdata`=A.
  - requests held high during RESP produce no second pulse.
- **Latency 1, wrap and priority:** with READ_LATENCY=WRITE_LATENCY=1 and LINE_IDX_BITS=10:
  - write B to 0x0000_0020, then read 0x0000_8020 (aliases to index 1) → resp at T+1, `pmem_rdata`=B.
  - assert read and write simultaneously with data C at 0x60 → treated as a write; a later read of 0x60 returns C.
- **Abort:** start a write of D at 0x80, then drop `pmem_write` at cycle T+5 (LAT=12) → no `pmem_resp`; a subsequent read of 0x80 returns the prior contents, not D.
- **Reset mid-write:** accept a write of E at 0xA0 and assert `rst` at T+11 (LAT=12) → no resp, FSM in IDLE; a read of 0xA0 returns the prior contents.
- **Back-to-back stress:** 200 random read/write ops over 64 lines, checked against a scoreboard model → every resp arrives exactly at T+LAT and every read matches the model.
